dmem_stride_agu: RTL and testbench
==================================

DMEM_STRIDE_AGU -- requirements
Module: dmem_stride_agu

Interface
REQ-001 SHALL have parameter: WIDTH_ADDR, 10, data-memory address/length/stride width (log2 of 1024-word data memory).
REQ-002 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: I_Req  input  1  load/store descriptor request (dmem_t.req).
REQ-005 SHALL have port: I_Len  input  WIDTH_ADDR  element count (dmem_t.len).
REQ-006 SHALL have port: I_Stride  input  WIDTH_ADDR  address increment per element (dmem_t.stride).
REQ-007 SHALL have port: I_Base  input  WIDTH_ADDR  first address (dmem_t.base).
REQ-008 SHALL have port: O_Ready  output  1  descriptor can be accepted.
REQ-009 SHALL have port: O_Valid  output  1  O_Addr carries a valid element address.
REQ-010 SHALL have port: O_Addr  output  WIDTH_ADDR  current element address.
REQ-011 SHALL have port: I_Grant  input  1  memory consumed O_Addr this cycle.
REQ-012 SHALL have port: O_Last  output  1  current address is final element.
REQ-013 SHALL have port: O_Done  output  1  one-cycle descriptor-complete pulse.
REQ-014 SHALL have port: O_Wrap  output  1  sticky address wrap-around flag (macro-dependent, REQ-031).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL drive O_Ready=1 only in IDLE.
REQ-017 SHALL accept a descriptor when I_Req && O_Ready; latch base, stride, len into internal registers.
REQ-018 SHALL transition IDLE->RUN on acceptance with I_Len!=0; IDLE->DONE on acceptance with I_Len==0 (no address emitted).
REQ-019 SHALL assert O_Valid=1 in RUN only; first O_Valid the cycle after acceptance (latency 1).
REQ-020 SHALL drive O_Addr = current address register when O_Valid=1, and 0 otherwise.
REQ-021 SHALL hold O_Addr and O_Last stable while O_Valid && !I_Grant.
REQ-022 SHALL on I_Grant in RUN with remaining>1: address <= (address + stride) mod 2^WIDTH_ADDR, remaining <= remaining-1.
REQ-023 SHALL on I_Grant in RUN with remaining==1: go to DONE.
REQ-024 SHALL assert O_Last = O_Valid && (remaining==1).
REQ-025 SHALL assert O_Done=1 for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-026 SHALL ignore I_Grant outside RUN and I_Req outside IDLE (no queuing; requester holds I_Req).
REQ-027 SHALL treat stride 0 as legal: same address emitted len times.
REQ-028 SHALL sustain one address per cycle when I_Grant held high; minimum descriptor turnaround = len+2 cycles.

Reset
REQ-029 SHALL on reset low, immediately force state IDLE, address/remaining/stride registers 0, O_Valid=0, O_Addr=0, O_Last=0, O_Done=0, O_Wrap=0, O_Ready=1 (after release); in-flight descriptor discarded, no O_Done issued.

Configuration
REQ-030 SHALL compile wrap detection only when macro DMEM_AGU_WRAP_CHECK_EN is defined.
REQ-031 SHALL, with DMEM_AGU_WRAP_CHECK_EN: set O_Wrap on any REQ-022 increment whose unwrapped sum exceeds 2^WIDTH_ADDR-1; clear O_Wrap on next descriptor acceptance; without it, O_Wrap tied 0 and no carry logic present.

Verification
REQ-032 SHALL cover: base=16, stride=4, len=3, I_Grant held 1 -> O_Addr 16,20,24 on consecutive cycles, O_Last with 24, O_Done next cycle.
REQ-033 SHALL cover: base=100, stride=1, len=2, I_Grant low 3 cycles then high -> O_Addr=100 held 4 cycles, then 101, O_Done.
REQ-034 SHALL cover: len=0, base=5 -> no O_Valid, O_Done pulse the cycle after acceptance, O_Ready back next cycle.
REQ-035 SHALL cover: base=1020, stride=8, len=2 -> O_Addr 1020 then 4; O_Wrap=1 with macro, 0 without.
REQ-036 SHALL cover: reset asserted while O_Valid=1 mid-descriptor (len=8) -> outputs zero asynchronously, no O_Done, new descriptor accepted after release.
REQ-037 SHALL cover: I_Req held through DONE with second descriptor base=0, stride=2, len=1 -> accepted in following IDLE cycle, O_Addr=0 with O_Last.

Source files
------------

// File: rtl/dmem_stride_agu_if.sv
// Descriptor and element-address handshake bundle for the strided data-memory AGU.
interface dmem_stride_agu_if #(
   parameter int WIDTH_ADDR = 10
);
   logic                  I_Req;
   logic [WIDTH_ADDR-1:0] I_Len;
   logic [WIDTH_ADDR-1:0] I_Stride;
   logic [WIDTH_ADDR-1:0] I_Base;
   logic                  O_Ready;
   logic                  O_Valid;
   logic [WIDTH_ADDR-1:0] O_Addr;
   logic                  I_Grant;
   logic                  O_Last;
   logic                  O_Done;
   logic                  O_Wrap;

   modport master (
      output I_Req, I_Len, I_Stride, I_Base, I_Grant,
      input  O_Ready, O_Valid, O_Addr, O_Last, O_Done, O_Wrap
   );

   modport slave (
      input  I_Req, I_Len, I_Stride, I_Base, I_Grant,
      output O_Ready, O_Valid, O_Addr, O_Last, O_Done, O_Wrap
   );
endinterface

// File: rtl/dmem_stride_agu.sv
// Strided data-memory address generator: one element address per grant.
// Define DMEM_AGU_WRAP_CHECK_EN to build the sticky O_Wrap carry detector.
module dmem_stride_agu #(
   parameter int WIDTH_ADDR = 10
) (
   input logic              clock,
   input logic              reset,
   dmem_stride_agu_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   localparam logic [WIDTH_ADDR-1:0] ONE = WIDTH_ADDR'(1);

   state_e                state_q, state_d;
   logic [WIDTH_ADDR-1:0] addr_q, addr_d;
   logic [WIDTH_ADDR-1:0] rem_q, rem_d;
   logic [WIDTH_ADDR-1:0] stride_q, stride_d;
   logic                  accept;
   logic                  step;
   logic                  valid;

   assign accept = bus.I_Req && (state_q == IDLE);
   assign step   = bus.I_Grant && (state_q == RUN) && (rem_q > ONE);
   assign valid  = (state_q == RUN);

`ifdef DMEM_AGU_WRAP_CHECK_EN
   logic [WIDTH_ADDR:0] sum;
   logic                wrap_q, wrap_d;

   assign sum = {1'b0, addr_q} + {1'b0, stride_q};

   always_comb begin
      wrap_d = wrap_q;
      if (accept) begin
         wrap_d = 1'b0;
      end else if (step && sum[WIDTH_ADDR]) begin
         wrap_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign bus.O_Wrap = wrap_q;
`else
   logic [WIDTH_ADDR-1:0] sum;

   assign sum        = addr_q + stride_q;
   assign bus.O_Wrap = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      stride_d = stride_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d   = bus.I_Base;
               stride_d = bus.I_Stride;
               rem_d    = bus.I_Len;
               state_d  = (bus.I_Len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (bus.I_Grant) begin
               if (rem_q > ONE) begin
                  addr_d = sum[WIDTH_ADDR-1:0];
                  rem_d  = rem_q - ONE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         stride_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         stride_q <= stride_d;
      end
   end

   // Outputs decode straight from state so reset clears them without a clock.
   assign bus.O_Ready = (state_q == IDLE);
   assign bus.O_Valid = valid;
   assign bus.O_Addr  = valid ? addr_q : '0;
   assign bus.O_Last  = valid && (rem_q == ONE);
   assign bus.O_Done  = (state_q == DONE);
endmodule

// File: tb/tb_dmem_stride_agu.sv
// Directed plus randomized bench for dmem_stride_agu against an arithmetic
// model of the strided address sequence.
module tb_dmem_stride_agu;
   localparam int W = 10;
   localparam int MEM = 1 << W;

   logic clock;
   logic reset;
   int   passed;
   int   total;

   dmem_stride_agu_if #(.WIDTH_ADDR(W)) bus ();

   dmem_stride_agu #(.WIDTH_ADDR(W)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic logic exp_wrap(input int base, input int stride,
                                     input int len);
`ifdef DMEM_AGU_WRAP_CHECK_EN
      return (len >= 2) && ((base + (len - 1) * stride) >= MEM);
`else
      return 1'b0;
`endif
   endfunction

   // mode 0: grant held, 1: random grant, 2: grant low 3 cycles then high.
   // Entered and left one time unit after a rising edge, DUT idle.
   task automatic run_desc(input int base, input int stride, input int len,
                           input int mode);
      int i;
      int cyc;
      int ea;
      bus.I_Base   = W'(base);
      bus.I_Stride = W'(stride);
      bus.I_Len    = W'(len);
      bus.I_Req    = 1'b1;
      @(negedge clock);
      chk("ready_idle", 32'(bus.O_Ready), 32'd1);
      @(posedge clock);
      #1;
      bus.I_Req = 1'b0;
      i   = 0;
      cyc = 0;
      while (i < len && cyc < 4 * len + 20) begin
         case (mode)
            0:       bus.I_Grant = 1'b1;
            1:       bus.I_Grant = 1'($urandom_range(0, 1));
            default: bus.I_Grant = (cyc >= 3);
         endcase
         ea = (base + i * stride) % MEM;
         @(negedge clock);
         chk("valid", 32'(bus.O_Valid), 32'd1);
         chk("addr", 32'(bus.O_Addr), 32'(ea));
         chk("last", 32'(bus.O_Last), 32'(i == len - 1));
         chk("ready_busy", 32'(bus.O_Ready), 32'd0);
         @(posedge clock);
         #1;
         if (bus.I_Grant) i++;
         cyc++;
      end
      bus.I_Grant = 1'b0;
      if (i < len) chk("run_timeout", 32'(i), 32'(len));
      @(negedge clock);
      chk("done", 32'(bus.O_Done), 32'd1);
      chk("valid_done", 32'(bus.O_Valid), 32'd0);
      chk("addr_done", 32'(bus.O_Addr), 32'd0);
      chk("wrap", 32'(bus.O_Wrap), 32'(exp_wrap(base, stride, len)));
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("done_clear", 32'(bus.O_Done), 32'd0);
      chk("ready_back", 32'(bus.O_Ready), 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      passed       = 0;
      total        = 0;
      reset        = 1'b0;
      bus.I_Req    = 1'b0;
      bus.I_Len    = '0;
      bus.I_Stride = '0;
      bus.I_Base   = '0;
      bus.I_Grant  = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_valid", 32'(bus.O_Valid), 32'd0);
      chk("rst_addr", 32'(bus.O_Addr), 32'd0);
      chk("rst_last", 32'(bus.O_Last), 32'd0);
      chk("rst_done", 32'(bus.O_Done), 32'd0);
      chk("rst_wrap", 32'(bus.O_Wrap), 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      run_desc(16, 4, 3, 0);
      run_desc(100, 1, 2, 2);
      run_desc(5, 3, 0, 0);
      run_desc(1020, 8, 2, 0);
      run_desc(33, 0, 3, 1);
      run_desc(1000, 1023, 4, 1);

      for (int k = 0; k < 10; k++) begin
         run_desc(int'($urandom_range(0, MEM - 1)),
                  int'($urandom_range(0, MEM - 1)),
                  int'($urandom_range(0, 7)), 1);
      end

      // Reset in the middle of a long descriptor.
      bus.I_Base   = W'(40);
      bus.I_Stride = W'(3);
      bus.I_Len    = W'(8);
      bus.I_Req    = 1'b1;
      bus.I_Grant  = 1'b1;
      @(negedge clock);
      @(posedge clock);
      #1;
      bus.I_Req = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("mid_valid", 32'(bus.O_Valid), 32'd1);
      chk("mid_addr", 32'(bus.O_Addr), 32'd49);
      #2;
      reset = 1'b0;
      #1;
      chk("async_valid", 32'(bus.O_Valid), 32'd0);
      chk("async_addr", 32'(bus.O_Addr), 32'd0);
      chk("async_last", 32'(bus.O_Last), 32'd0);
      chk("async_done", 32'(bus.O_Done), 32'd0);
      @(posedge clock);
      #1;
      bus.I_Grant = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("post_rst_done", 32'(bus.O_Done), 32'd0);
      chk("post_rst_ready", 32'(bus.O_Ready), 32'd1);
      chk("post_rst_valid", 32'(bus.O_Valid), 32'd0);
      @(posedge clock);
      #1;
      run_desc(200, 5, 4, 1);

      // Request held through DONE picks up the next descriptor.
      bus.I_Base   = W'(7);
      bus.I_Stride = W'(3);
      bus.I_Len    = W'(1);
      bus.I_Req    = 1'b1;
      bus.I_Grant  = 1'b1;
      @(negedge clock);
      chk("b2b_ready0", 32'(bus.O_Ready), 32'd1);
      @(posedge clock);
      #1;
      bus.I_Base   = W'(0);
      bus.I_Stride = W'(2);
      bus.I_Len    = W'(1);
      @(negedge clock);
      chk("b2b_addr0", 32'(bus.O_Addr), 32'd7);
      chk("b2b_last0", 32'(bus.O_Last), 32'd1);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("b2b_done0", 32'(bus.O_Done), 32'd1);
      chk("b2b_noready", 32'(bus.O_Ready), 32'd0);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("b2b_ready1", 32'(bus.O_Ready), 32'd1);
      @(posedge clock);
      #1;
      bus.I_Req = 1'b0;
      @(negedge clock);
      chk("b2b_valid1", 32'(bus.O_Valid), 32'd1);
      chk("b2b_addr1", 32'(bus.O_Addr), 32'd0);
      chk("b2b_last1", 32'(bus.O_Last), 32'd1);
      @(posedge clock);
      #1;
      bus.I_Grant = 1'b0;
      @(negedge clock);
      chk("b2b_done1", 32'(bus.O_Done), 32'd1);
      chk("b2b_wrap1", 32'(bus.O_Wrap), 32'd0);
      @(posedge clock);
      #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
